rtu_port_arbiter: RTL and testbench
===================================

Name: rtu_port_arbiter

Overview:
Shares one RTU lookup engine between g_num_ports switch ports. Each port presents per-port request/response signals in the same flattened-vector form the RTU wrapper uses. The block holds one request per port, issues held requests to the engine in round-robin order, and routes the tagged engine responses back to their ports. Each port keeps its response until it acknowledges it.

Parameters:
g_num_ports, 16, number of requesting ports
g_port_id_width, 4, width of the port tag; must equal ceil(log2(g_num_ports))
g_mac_addr_width, 48, MAC address width
g_vid_num_width, 12, VLAN ID width
g_prio_num_width, 3, priority width
g_port_mask_bits, 16, destination port mask width

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
rtu_idle_o  out  N  per port: 1 = port may strobe a new request
rq_strobe_p_i  in  N  per port: single-cycle request pulse
rq_smac_i / rq_dmac_i  in  N*48  source / destination MAC, flattened, port i at [i*W +: W]
rq_vid_i  in  N*12  VLAN ID
rq_has_vid_i  in  N  VLAN ID field valid
rq_prio_i  in  N*3  priority
rq_has_prio_i  in  N  priority field valid
rsp_valid_o  out  N  per port: response held
rsp_dst_port_mask_o  out  N*16  destination port mask
rsp_drop_o  out  N  drop flag
rsp_prio_o  out  N*3  resolved priority
rsp_ack_i  in  N  per port: response consumed
eng_rq_valid_o  out  1  request to engine valid
eng_rq_ready_i  in  1  engine accepts the request
eng_rq_port_o  out  4  port tag
eng_rq_smac_o, eng_rq_dmac_o, eng_rq_vid_o, eng_rq_has_vid_o, eng_rq_prio_o, eng_rq_has_prio_o  out  48/48/12/1/3/1  request fields
eng_rsp_valid_i  in  1  engine response pulse
eng_rsp_port_i  in  4  tag of the response
eng_rsp_dst_port_mask_i  in  16  response mask
eng_rsp_drop_i  in  1  response drop flag
eng_rsp_prio_i  in  3  response priority
err_overrun_o  out  1  pulse: a strobe arrived on a port that was not idle
err_spurious_o  out  1  pulse: a response arrived for a port not in ISSUED

Behaviour:
- Reset values:
  - All per-port state machines go to IDLE, so rtu_idle_o is all ones.
  - rsp_valid_o = 0, eng_rq_valid_o = 0, err_* = 0, round-robin pointer = 0.
  - All data outputs are 0.
- Per-port FSM:
  - IDLE -> PENDING on strobe. All request fields are captured at the same edge.
  - PENDING -> ISSUED when the port is granted and loaded into the engine output register.
  - ISSUED -> RESP on eng_rsp_valid_i with a matching tag. Mask, drop and prio are captured.
  - RESP -> IDLE on rsp_ack_i.
- rtu_idle_o[i] = (state == IDLE). rsp_valid_o[i] = (state == RESP). Response fields stay stable throughout RESP.
- Strobe in any state other than IDLE:
  - The strobe is ignored and the held data is unchanged.
  - err_overrun_o pulses for 1 cycle.
- rsp_ack_i outside RESP is ignored.
- A strobe in the same cycle as the ack is ignored, because rtu_idle_o is still 0 in that cycle; it flags an overrun.
- Engine output register:
  - The register is free when eng_rq_valid_o = 0, or when eng_rq_valid_o & eng_rq_ready_i (same-cycle reload).
  - When free and at least one port is PENDING, the round-robin winner is loaded and eng_rq_valid_o = 1.
  - The pointer then moves to winner + 1 mod N.
  - While valid & !ready, all eng_rq_* outputs hold stable.
- Throughput: back-to-back issue is one request per cycle while ready stays high.
- Latency: strobe at edge 0 -> PENDING at edge 1 -> eng_rq_valid_o at edge 2, if the output register is free.
- Engine response:
  - Responses may return out of order and several may be outstanding.
  - Each port has at most one outstanding request, by construction of the FSM.
  - A response for a port not in ISSUED is dropped and err_spurious_o pulses for 1 cycle.
  - A response whose tag is >= g_num_ports is treated the same way.
  - The response is visible as rsp_valid_o 1 cycle after eng_rsp_valid_i.
- Simultaneous events in one cycle (strobe on port A, grant of B, response for C, ack on D) are all processed independently.
- Reset mid-operation: all state clears immediately. Engine responses that arrive after reset are spurious and are dropped.

Decomposition:
- Package rtu_arb_pkg:
  - t_rtu_port_state enum {IDLE, PENDING, ISSUED, RESP}.
  - Record types t_rtu_request and t_rtu_response.
  - Function f_log2_size.
- Sub-module rtu_rr_arbiter: N-bit request vector, enable, pointer register -> one-hot grant plus grant index. Purely round-robin, with the pointer updated only when enable is high.

Test Plan:
- Single request:
  - Stimulus: port 3 strobes with dmac 0x0011_2233_4455; engine ready, responds with mask 0x0006, drop 0, prio 5 three cycles later.
  - Response: eng_rq_valid_o at edge 2 with tag 3; rsp_valid_o[3] = 1 with mask 0x0006 and prio 5 until ack; rtu_idle_o[3] = 1 one cycle after ack.
- Round robin:
  - Stimulus: ports 0, 5 and 15 strobe in the same cycle; ready held high.
  - Response: tags issued in order 0, 5, 15 on 3 consecutive cycles; repeat with the pointer at 6 -> order 15, 0, 5.
- Backpressure:
  - Stimulus: ready low for 10 cycles with 4 ports pending.
  - Response: eng_rq_* stable through the stall; after ready rises, one issue per cycle.
- Out-of-order responses:
  - Stimulus: issue tags 1 and 2; engine answers 2 then 1.
  - Response: each response is routed to the correct port with the correct fields.
- Error cases:
  - Stimulus: strobe port 7 while it is PENDING; inject a response with tag 9 while port 9 is IDLE.
  - Response: one pulse on each err_* output; the state of port 7 and port 9 is unchanged.
- Reset mid-operation:
  - Stimulus: assert reset with 3 ports ISSUED, then deliver their responses after reset.
  - Response: all outputs return to reset values; each response gives err_spurious_o with no rsp_valid_o.

Source files
------------

// File: rtl/rtu_arb_pkg.sv
// Shared types for the RTU port arbiter: per-port state, request/response records
// and a sizing helper.
package rtu_arb_pkg;

    localparam int c_mac_addr_width = 48;
    localparam int c_vid_num_width  = 12;
    localparam int c_prio_num_width = 3;
    localparam int c_port_mask_bits = 16;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ISSUED,
        RESP
    } t_rtu_port_state;

    typedef struct packed {
        logic [c_mac_addr_width-1:0] smac;
        logic [c_mac_addr_width-1:0] dmac;
        logic [c_vid_num_width-1:0]  vid;
        logic                        has_vid;
        logic [c_prio_num_width-1:0] prio;
        logic                        has_prio;
    } t_rtu_request;

    typedef struct packed {
        logic [c_port_mask_bits-1:0] dst_port_mask;
        logic                        drop;
        logic [c_prio_num_width-1:0] prio;
    } t_rtu_response;

    // Bits needed to index n items; never less than one.
    function automatic int f_log2_size(input int n);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rtu_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after the pointer wins; the pointer
// moves past the winner only on cycles where the grant is actually taken.
module rtu_rr_arbiter
    import rtu_arb_pkg::*;
#(
    parameter int g_num       = 16,
    parameter int g_idx_width = f_log2_size(g_num)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [g_num-1:0]       req,
    input  logic                   en,
    output logic [g_num-1:0]       grant,
    output logic [g_idx_width-1:0] grant_idx,
    output logic                   any_grant
);

    logic [g_idx_width-1:0] ptr_q;

    always_comb begin
        logic [g_idx_width-1:0] k;
        k         = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = 0; i < g_num; i++) begin
            k = g_idx_width'((int'(ptr_q) + i) % g_num);
            if (!any_grant && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = k;
                any_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en && any_grant) begin
            ptr_q <= (int'(grant_idx) == g_num - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rtu_port_arbiter.sv
// Shares one RTU lookup engine between g_num_ports ports: one held request per port,
// round-robin issue, tagged out-of-order responses routed back and held until ack.
module rtu_port_arbiter
    import rtu_arb_pkg::*;
#(
    parameter int g_num_ports      = 16,
    parameter int g_port_id_width  = 4,
    parameter int g_mac_addr_width = c_mac_addr_width,
    parameter int g_vid_num_width  = c_vid_num_width,
    parameter int g_prio_num_width = c_prio_num_width,
    parameter int g_port_mask_bits = c_port_mask_bits
) (
    input  logic                                     clk_i,
    input  logic                                     rst_n_i,
    output logic [g_num_ports-1:0]                   rtu_idle_o,
    input  logic [g_num_ports-1:0]                   rq_strobe_p_i,
    input  logic [g_num_ports*g_mac_addr_width-1:0]  rq_smac_i,
    input  logic [g_num_ports*g_mac_addr_width-1:0]  rq_dmac_i,
    input  logic [g_num_ports*g_vid_num_width-1:0]   rq_vid_i,
    input  logic [g_num_ports-1:0]                   rq_has_vid_i,
    input  logic [g_num_ports*g_prio_num_width-1:0]  rq_prio_i,
    input  logic [g_num_ports-1:0]                   rq_has_prio_i,
    output logic [g_num_ports-1:0]                   rsp_valid_o,
    output logic [g_num_ports*g_port_mask_bits-1:0]  rsp_dst_port_mask_o,
    output logic [g_num_ports-1:0]                   rsp_drop_o,
    output logic [g_num_ports*g_prio_num_width-1:0]  rsp_prio_o,
    input  logic [g_num_ports-1:0]                   rsp_ack_i,
    output logic                                     eng_rq_valid_o,
    input  logic                                     eng_rq_ready_i,
    output logic [g_port_id_width-1:0]               eng_rq_port_o,
    output logic [g_mac_addr_width-1:0]              eng_rq_smac_o,
    output logic [g_mac_addr_width-1:0]              eng_rq_dmac_o,
    output logic [g_vid_num_width-1:0]               eng_rq_vid_o,
    output logic                                     eng_rq_has_vid_o,
    output logic [g_prio_num_width-1:0]              eng_rq_prio_o,
    output logic                                     eng_rq_has_prio_o,
    input  logic                                     eng_rsp_valid_i,
    input  logic [g_port_id_width-1:0]               eng_rsp_port_i,
    input  logic [g_port_mask_bits-1:0]              eng_rsp_dst_port_mask_i,
    input  logic                                     eng_rsp_drop_i,
    input  logic [g_prio_num_width-1:0]              eng_rsp_prio_i,
    output logic                                     err_overrun_o,
    output logic                                     err_spurious_o
);

    // state_q is the per-port FSM state, kept as a named array for checker binding.
    t_rtu_port_state            state_q [g_num_ports];
    t_rtu_request               req_q   [g_num_ports];
    t_rtu_response              rsp_q   [g_num_ports];
    t_rtu_request               eng_rq_q;
    logic [g_port_id_width-1:0] eng_port_q;
    logic                       eng_valid_q;
    logic                       err_overrun_q;
    logic                       err_spurious_q;
    logic [g_num_ports-1:0]     pending;
    logic [g_num_ports-1:0]     rsp_hit;
    logic [g_num_ports-1:0]     grant;
    logic [g_port_id_width-1:0] grant_idx;
    logic                       any_grant;
    logic                       reg_free;

    // Engine handshake: a request transfers on a cycle with eng_rq_valid_o & eng_rq_ready_i;
    // once valid is raised, the request fields hold until that transfer, and the register
    // can be reloaded in the transfer cycle itself.
    assign reg_free = !eng_valid_q || eng_rq_ready_i;

    rtu_rr_arbiter #(
        .g_num       (g_num_ports),
        .g_idx_width (g_port_id_width)
    ) u_rr (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .req       (pending),
        .en        (reg_free),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        pending             = '0;
        rsp_hit             = '0;
        rtu_idle_o          = '0;
        rsp_valid_o         = '0;
        rsp_dst_port_mask_o = '0;
        rsp_drop_o          = '0;
        rsp_prio_o          = '0;
        for (int i = 0; i < g_num_ports; i++) begin
            pending[i]     = (state_q[i] == PENDING);
            rsp_hit[i]     = eng_rsp_valid_i && (state_q[i] == ISSUED) &&
                             (eng_rsp_port_i == g_port_id_width'(i));
            rtu_idle_o[i]  = (state_q[i] == IDLE);
            rsp_valid_o[i] = (state_q[i] == RESP);
            rsp_dst_port_mask_o[i*g_port_mask_bits +: g_port_mask_bits] = rsp_q[i].dst_port_mask;
            rsp_drop_o[i]  = rsp_q[i].drop;
            rsp_prio_o[i*g_prio_num_width +: g_prio_num_width] = rsp_q[i].prio;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < g_num_ports; i++) begin
                state_q[i] <= IDLE;
                req_q[i]   <= '0;
                rsp_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < g_num_ports; i++) begin
                case (state_q[i])
                    IDLE: if (rq_strobe_p_i[i]) begin
                        state_q[i] <= PENDING;
                        req_q[i]   <= '{
                            smac:     rq_smac_i[i*g_mac_addr_width +: g_mac_addr_width],
                            dmac:     rq_dmac_i[i*g_mac_addr_width +: g_mac_addr_width],
                            vid:      rq_vid_i[i*g_vid_num_width +: g_vid_num_width],
                            has_vid:  rq_has_vid_i[i],
                            prio:     rq_prio_i[i*g_prio_num_width +: g_prio_num_width],
                            has_prio: rq_has_prio_i[i]
                        };
                    end
                    PENDING: if (reg_free && grant[i]) state_q[i] <= ISSUED;
                    ISSUED: if (rsp_hit[i]) begin
                        state_q[i] <= RESP;
                        rsp_q[i]   <= '{
                            dst_port_mask: eng_rsp_dst_port_mask_i,
                            drop:          eng_rsp_drop_i,
                            prio:          eng_rsp_prio_i
                        };
                    end
                    RESP: if (rsp_ack_i[i]) state_q[i] <= IDLE;
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            eng_valid_q    <= 1'b0;
            eng_port_q     <= '0;
            eng_rq_q       <= '0;
            err_overrun_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            if (reg_free) begin
                eng_valid_q <= any_grant;
                if (any_grant) begin
                    eng_port_q <= grant_idx;
                    eng_rq_q   <= req_q[grant_idx];
                end
            end
            err_overrun_q  <= |(rq_strobe_p_i & ~rtu_idle_o);
            err_spurious_q <= eng_rsp_valid_i && !(|rsp_hit);
        end
    end

    assign eng_rq_valid_o    = eng_valid_q;
    assign eng_rq_port_o     = eng_port_q;
    assign eng_rq_smac_o     = eng_rq_q.smac;
    assign eng_rq_dmac_o     = eng_rq_q.dmac;
    assign eng_rq_vid_o      = eng_rq_q.vid;
    assign eng_rq_has_vid_o  = eng_rq_q.has_vid;
    assign eng_rq_prio_o     = eng_rq_q.prio;
    assign eng_rq_has_prio_o = eng_rq_q.has_prio;
    assign err_overrun_o     = err_overrun_q;
    assign err_spurious_o    = err_spurious_q;

endmodule

// File: tb/tb_rtu_port_arbiter.sv
// Directed bench for rtu_port_arbiter: hand-computed expectations for issue order,
// response routing, backpressure, error pulses and mid-operation reset.
module tb_rtu_port_arbiter;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   rtu_idle;
    logic [N-1:0]   rq_strobe_p = '0;
    logic [N*48-1:0] rq_smac = '0;
    logic [N*48-1:0] rq_dmac = '0;
    logic [N*12-1:0] rq_vid = '0;
    logic [N-1:0]   rq_has_vid = '0;
    logic [N*3-1:0] rq_prio = '0;
    logic [N-1:0]   rq_has_prio = '0;
    logic [N-1:0]   rsp_valid;
    logic [N*16-1:0] rsp_mask;
    logic [N-1:0]   rsp_drop;
    logic [N*3-1:0] rsp_prio;
    logic [N-1:0]   rsp_ack = '0;
    logic           eng_rq_valid;
    logic           eng_rq_ready = 1'b0;
    logic [3:0]     eng_rq_port;
    logic [47:0]    eng_rq_smac, eng_rq_dmac;
    logic [11:0]    eng_rq_vid;
    logic           eng_rq_has_vid;
    logic [2:0]     eng_rq_prio;
    logic           eng_rq_has_prio;
    logic           eng_rsp_valid = 1'b0;
    logic [3:0]     eng_rsp_port = '0;
    logic [15:0]    eng_rsp_mask = '0;
    logic           eng_rsp_drop = 1'b0;
    logic [2:0]     eng_rsp_prio = '0;
    logic           err_overrun, err_spurious;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];

    rtu_port_arbiter dut (
        .clk_i                   (clk),
        .rst_n_i                 (rst_n),
        .rtu_idle_o              (rtu_idle),
        .rq_strobe_p_i           (rq_strobe_p),
        .rq_smac_i               (rq_smac),
        .rq_dmac_i               (rq_dmac),
        .rq_vid_i                (rq_vid),
        .rq_has_vid_i            (rq_has_vid),
        .rq_prio_i               (rq_prio),
        .rq_has_prio_i           (rq_has_prio),
        .rsp_valid_o             (rsp_valid),
        .rsp_dst_port_mask_o     (rsp_mask),
        .rsp_drop_o              (rsp_drop),
        .rsp_prio_o              (rsp_prio),
        .rsp_ack_i               (rsp_ack),
        .eng_rq_valid_o          (eng_rq_valid),
        .eng_rq_ready_i          (eng_rq_ready),
        .eng_rq_port_o           (eng_rq_port),
        .eng_rq_smac_o           (eng_rq_smac),
        .eng_rq_dmac_o           (eng_rq_dmac),
        .eng_rq_vid_o            (eng_rq_vid),
        .eng_rq_has_vid_o        (eng_rq_has_vid),
        .eng_rq_prio_o           (eng_rq_prio),
        .eng_rq_has_prio_o       (eng_rq_has_prio),
        .eng_rsp_valid_i         (eng_rsp_valid),
        .eng_rsp_port_i          (eng_rsp_port),
        .eng_rsp_dst_port_mask_i (eng_rsp_mask),
        .eng_rsp_drop_i          (eng_rsp_drop),
        .eng_rsp_prio_i          (eng_rsp_prio),
        .err_overrun_o           (err_overrun),
        .err_spurious_o          (err_spurious)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    // ---- checking and driver tasks ----
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] dmac_of(input int p);
        return 48'hD0D0_0000_0000 + 48'(p);
    endfunction

    task automatic set_dmac(input int p, input logic [47:0] d);
        rq_dmac[p*48 +: 48] = d;
    endtask

    task automatic strobe(input logic [N-1:0] m);
        rq_strobe_p = m;
        tick();
        rq_strobe_p = '0;
    endtask

    task automatic respond(input int p, input logic [15:0] m, input logic d, input logic [2:0] pr);
        eng_rsp_port  = 4'(p);
        eng_rsp_mask  = m;
        eng_rsp_drop  = d;
        eng_rsp_prio  = pr;
        eng_rsp_valid = 1'b1;
        tick();
        eng_rsp_valid = 1'b0;
    endtask

    task automatic ack(input logic [N-1:0] m);
        rsp_ack = m;
        tick();
        rsp_ack = '0;
    endtask

    task automatic issue_seq(input string tag);
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            check({tag, "_valid"}, eng_rq_valid, 1'b1);
            check({tag, "_tag"}, eng_rq_port, e[3:0]);
        end
    endtask

    task automatic serve(input int p);
        logic [15:0] m;
        m = 16'h1 << p;
        respond(p, m, 1'b0, 3'(p));
        check("serve_rsp_valid", rsp_valid[p], 1'b1);
        check("serve_rsp_mask", rsp_mask[p*16 +: 16], m);
        ack(m);
        check("serve_idle", rtu_idle[p], 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_idle"}, rtu_idle, 16'hFFFF);
        check({tag, "_rsp_valid"}, rsp_valid, 16'h0);
        check({tag, "_rsp_mask"}, rsp_mask[63:0], 64'h0);
        check({tag, "_eng_valid"}, eng_rq_valid, 1'b0);
        check({tag, "_eng_port"}, eng_rq_port, 4'h0);
        check({tag, "_eng_dmac"}, eng_rq_dmac, 48'h0);
        check({tag, "_err_ovr"}, err_overrun, 1'b0);
        check({tag, "_err_spur"}, err_spurious, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---- stimulus ----
    initial begin
        for (int p = 0; p < N; p++) begin
            rq_smac[p*48 +: 48] = 48'h5A00_0000_0000 + 48'(p);
            rq_dmac[p*48 +: 48] = dmac_of(p);
            rq_vid[p*12 +: 12]  = 12'h100 + 12'(p);
            rq_prio[p*3 +: 3]   = 3'(p);
            rq_has_vid[p]       = 1'b1;
            rq_has_prio[p]      = p[0];
        end

        tick();
        tick();
        reset_checks("rst_held");
        rst_n = 1'b1;
        tick();
        reset_checks("rst_rel");

        // Single request on port 3
        eng_rq_ready = 1'b1;
        set_dmac(3, 48'h0011_2233_4455);
        strobe(16'h0008);
        check("t1_idle3_low", rtu_idle[3], 1'b0);
        check("t1_no_valid_e1", eng_rq_valid, 1'b0);
        tick();
        check("t1_valid_e2", eng_rq_valid, 1'b1);
        check("t1_tag", eng_rq_port, 4'd3);
        check("t1_dmac", eng_rq_dmac, 48'h0011_2233_4455);
        check("t1_smac", eng_rq_smac, 48'h5A00_0000_0003);
        check("t1_vid", eng_rq_vid, 12'h103);
        check("t1_prio", eng_rq_prio, 3'd3);
        check("t1_has_prio", eng_rq_has_prio, 1'b1);
        tick();
        check("t1_valid_drop", eng_rq_valid, 1'b0);
        tick();
        tick();
        respond(3, 16'h0006, 1'b0, 3'd5);
        check("t1_rsp_valid", rsp_valid, 16'h0008);
        check("t1_rsp_mask", rsp_mask[3*16 +: 16], 16'h0006);
        check("t1_rsp_prio", rsp_prio[3*3 +: 3], 3'd5);
        check("t1_rsp_drop", rsp_drop[3], 1'b0);
        tick();
        tick();
        check("t1_rsp_hold", rsp_valid, 16'h0008);
        check("t1_mask_hold", rsp_mask[3*16 +: 16], 16'h0006);
        ack(16'h0008);
        check("t1_idle_after_ack", rtu_idle, 16'hFFFF);
        check("t1_rsp_clr", rsp_valid, 16'h0);

        // Round robin from pointer 0, then from pointer 6
        do_reset();
        set_dmac(3, dmac_of(3));
        eng_rq_ready = 1'b1;
        strobe(16'h8021);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd5);
        exp_q.push_back(16'd15);
        issue_seq("t2a");
        tick();
        check("t2_drain", eng_rq_valid, 1'b0);
        serve(0);
        serve(5);
        serve(15);
        strobe(16'h0020);
        exp_q.push_back(16'd5);
        issue_seq("t2_ptr");
        serve(5);
        strobe(16'h8021);
        exp_q.push_back(16'd15);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd5);
        issue_seq("t2b");
        serve(15);
        serve(0);
        serve(5);

        // Backpressure with ports 1,2,8,9 pending, pointer at 6
        eng_rq_ready = 1'b0;
        strobe(16'h0306);
        tick();
        for (int c = 0; c < 10; c++) begin
            check("t3_stall_valid", eng_rq_valid, 1'b1);
            check("t3_stall_tag", eng_rq_port, 4'd8);
            check("t3_stall_dmac", eng_rq_dmac, dmac_of(8));
            tick();
        end
        eng_rq_ready = 1'b1;
        exp_q.push_back(16'd9);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        issue_seq("t3_drain");
        serve(8);
        serve(9);
        serve(1);
        serve(2);

        // Out-of-order responses for ports 1 and 2
        strobe(16'h0006);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        issue_seq("t4");
        respond(2, 16'h00F0, 1'b1, 3'd2);
        check("t4_rsp2_valid", rsp_valid, 16'h0004);
        check("t4_rsp2_mask", rsp_mask[2*16 +: 16], 16'h00F0);
        check("t4_rsp2_drop", rsp_drop[2], 1'b1);
        check("t4_rsp2_prio", rsp_prio[2*3 +: 3], 3'd2);
        respond(1, 16'h0A0A, 1'b0, 3'd7);
        check("t4_rsp_both", rsp_valid, 16'h0006);
        check("t4_rsp1_mask", rsp_mask[1*16 +: 16], 16'h0A0A);
        check("t4_rsp1_prio", rsp_prio[1*3 +: 3], 3'd7);
        check("t4_rsp1_drop", rsp_drop[1], 1'b0);
        check("t4_rsp2_stable", rsp_mask[2*16 +: 16], 16'h00F0);
        rsp_ack = 16'h0006;
        rq_strobe_p = 16'h0002;
        tick();
        rsp_ack = '0;
        rq_strobe_p = '0;
        check("t4_ack_strobe_ovr", err_overrun, 1'b1);
        check("t4_ack_idle", rtu_idle, 16'hFFFF);
        check("t4_ack_rsp_clr", rsp_valid, 16'h0);
        tick();
        check("t4_strobe_ignored", eng_rq_valid, 1'b0);
        check("t4_ovr_pulse_end", err_overrun, 1'b0);

        // Overrun on a PENDING port and a spurious response
        eng_rq_ready = 1'b0;
        strobe(16'h0010);
        tick();
        check("t5_busy_tag", eng_rq_port, 4'd4);
        set_dmac(7, 48'hAAAA_0000_0007);
        strobe(16'h0080);
        check("t5_no_ovr", err_overrun, 1'b0);
        check("t5_idle7_low", rtu_idle[7], 1'b0);
        set_dmac(7, 48'hBBBB_0000_0007);
        strobe(16'h0080);
        check("t5_ovr_pulse", err_overrun, 1'b1);
        tick();
        check("t5_ovr_end", err_overrun, 1'b0);
        respond(9, 16'hFFFF, 1'b1, 3'd1);
        check("t5_spur_pulse", err_spurious, 1'b1);
        check("t5_spur_no_rsp", rsp_valid, 16'h0);
        check("t5_idle9", rtu_idle[9], 1'b1);
        tick();
        check("t5_spur_end", err_spurious, 1'b0);
        eng_rq_ready = 1'b1;
        tick();
        check("t5_p7_tag", eng_rq_port, 4'd7);
        check("t5_p7_dmac_kept", eng_rq_dmac, 48'hAAAA_0000_0007);
        tick();
        check("t5_drain", eng_rq_valid, 1'b0);
        serve(4);
        serve(7);

        // Reset with ports 10,11,12 ISSUED; late responses are spurious
        strobe(16'h1C00);
        exp_q.push_back(16'd10);
        exp_q.push_back(16'd11);
        exp_q.push_back(16'd12);
        issue_seq("t6");
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("t6_async");
        tick();
        rst_n = 1'b1;
        for (int p = 10; p <= 12; p++) begin
            respond(p, 16'h1234, 1'b0, 3'd3);
            check("t6_late_spur", err_spurious, 1'b1);
            check("t6_late_no_rsp", rsp_valid, 16'h0);
        end
        tick();
        check("t6_spur_end", err_spurious, 1'b0);
        check("t6_idle", rtu_idle, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
